axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_pkg.sv | 22 ++
 rtl/axil_cmd_master.sv | 170 +++++++++++++++++
 tb/tb_axil_cmd_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: command-master FSM states, response codes and
// the saturating error-counter increment.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WRESP,
    ST_RD,
    ST_RDATA,
    ST_RESP
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI
// transaction and holds the completion until the requester consumes it.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  axil_state_e             r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic                    r_awvalid, r_wvalid, r_aw_done, r_w_done;
  logic                    r_arvalid, r_bready, r_rready;
  logic                    r_rsp_valid, r_rsp_write;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_resp;
  logic [15:0]             r_err_count;

  logic w_aw_hs, w_w_hs, w_aw_ok, w_w_ok;

  assign w_aw_hs = r_awvalid & m_axi_awready;
  assign w_w_hs  = r_wvalid & m_axi_wready;
  // A channel counts as finished if it completed earlier or completes now.
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_wstrb <= cmd_wstrb;
            if (cmd_write) begin
              r_state   <= ST_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= ST_RD;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_state  <= ST_WRESP;
            r_bready <= 1'b1;
          end
        end
        ST_WRESP: begin
          if (m_axi_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= m_axi_bresp;
            if (m_axi_bresp != RESP_OKAY) r_err_count <= sat_inc16(r_err_count);
            r_state     <= ST_RESP;
          end
        end
        ST_RD: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= m_axi_rdata;
            r_rsp_resp  <= m_axi_rresp;
            if (m_axi_rresp != RESP_OKAY) r_err_count <= sat_inc16(r_err_count);
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign err_count     = r_err_count;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a 4-word register slave with adjustable ready
// delays, a directed command table and hand-written multi-cycle sequences.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [15:0] err_count;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // Register slave: 4 words at 0x00..0x0C, DECERR above; ready after N stalled cycles.
  int          aw_wait = 0, w_wait = 0;
  logic        rd_err = 1'b0;
  int          aw_cnt, w_cnt, b_count;
  logic [31:0] mem [4];
  logic        s_aw_got, s_w_got;
  logic [31:0] s_awaddr, s_wdata, s_a_now, s_d_now;
  logic [3:0]  s_wstrb, s_s_now;
  logic        s_aw_hs, s_w_hs;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
  assign m_axi_arready = m_axi_arvalid;
  assign s_aw_hs = m_axi_awvalid && m_axi_awready;
  assign s_w_hs  = m_axi_wvalid && m_axi_wready;
  assign s_a_now = s_aw_hs ? m_axi_awaddr : s_awaddr;
  assign s_d_now = s_w_hs ? m_axi_wdata : s_wdata;
  assign s_s_now = s_w_hs ? m_axi_wstrb : s_wstrb;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; b_count <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      if (s_aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= m_axi_awaddr; end
      if (s_w_hs) begin s_w_got <= 1'b1; s_wdata <= m_axi_wdata; s_wstrb <= m_axi_wstrb; end
      if ((s_aw_got || s_aw_hs) && (s_w_got || s_w_hs) && !m_axi_bvalid) begin
        s_aw_got <= 1'b0; s_w_got <= 1'b0;
        m_axi_bvalid <= 1'b1;
        if (s_a_now < 32'd16) begin
          for (int b = 0; b < 4; b++)
            if (s_s_now[b]) mem[s_a_now[3:2]][8*b +: 8] <= s_d_now[8*b +: 8];
          m_axi_bresp <= 2'b00;
        end else begin
          m_axi_bresp <= 2'b11;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
        b_count <= b_count + 1;
      end
      if (m_axi_arvalid && m_axi_arready && !m_axi_rvalid) begin
        m_axi_rvalid <= 1'b1;
        if (m_axi_araddr < 32'd16) begin
          m_axi_rdata <= mem[m_axi_araddr[3:2]];
          m_axi_rresp <= rd_err ? 2'b10 : 2'b00;
        end else begin
          m_axi_rdata <= '0;
          m_axi_rresp <= rd_err ? 2'b10 : 2'b11;
        end
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  int n_cpl = 0;
  always @(posedge clk) if (!rst && rsp_valid && rsp_ready) n_cpl <= n_cpl + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int extra);
    extra = 0;
    while (!rsp_valid && extra < 60) begin
      @(posedge clk); #1;
      extra++;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    int extra;
    int b0, c0;
    vecs[0] = '{1'b1, 32'h00, 32'h0000000B, 4'hF, 32'h00000000, 2'b00, 16'd0};
    vecs[1] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0000000B, 2'b00, 16'd0};
    vecs[2] = '{1'b1, 32'h04, 32'h00000001, 4'hF, 32'h00000000, 2'b00, 16'd0};
    vecs[3] = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h00000000, 2'b00, 16'd0};
    vecs[4] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h00BB00DD, 2'b00, 16'd0};
    vecs[5] = '{1'b1, 32'h00, 32'h12345678, 4'h2, 32'h00000000, 2'b00, 16'd0};
    vecs[6] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0000560B, 2'b00, 16'd0};
    vecs[7] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h00000001, 2'b00, 16'd0};
    vecs[8] = '{1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'h00000000, 2'b11, 16'd1};
    vecs[9] = '{1'b0, 32'h24, 32'h0,        4'h0, 32'h00000000, 2'b11, 16'd2};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_axi_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                             m_axi_bready, m_axi_rready}, 32'd0);

    // Zero-wait table: accept cycle, WR/RD, WRESP/RDATA, then RESP = cycle 4.
    for (int i = 0; i < 10; i++) begin
      start_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      wait_rsp(extra);
      check($sformatf("v%0d_latency_cycles", i), 32'(extra + 2), 32'd4);
      check($sformatf("v%0d_rsp_write", i), 32'(rsp_write), 32'(vecs[i].wr));
      check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_rsp_resp", i), 32'(rsp_resp), 32'(vecs[i].exp_resp));
      check($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_err));
      complete();
    end

    // Response backpressure on a read of 0x04.
    rsp_ready = 1'b0;
    start_cmd(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp(extra);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'h00000001);
      check("bp_cmd_ready_busy", {30'd0, cmd_ready, busy}, 32'b01);
    end
    complete();

    // AW/W skew: W accepted immediately, AW three cycles later.
    aw_wait = 3; w_wait = 0;
    b0 = b_count; c0 = n_cpl;
    start_cmd(1'b1, 32'h0C, 32'h00000055, 4'hF);
    check("skew_valids_first_wr", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'b11);
    @(posedge clk); #1;
    check("skew_w_dropped", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'b10);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("skew_aw_held", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'b10);
      check("skew_awaddr_stable", m_axi_awaddr, 32'h0C);
    end
    @(posedge clk); #1;
    check("skew_aw_dropped", 32'(m_axi_awvalid), 32'd0);
    wait_rsp(extra);
    check("skew_rsp_write", 32'(rsp_write), 32'd1);
    check("skew_rsp_resp", 32'(rsp_resp), 32'd0);
    complete();
    repeat (2) @(posedge clk);
    #1;
    check("skew_one_b", 32'(b_count - b0), 32'd1);
    check("skew_one_completion", 32'(n_cpl - c0), 32'd1);
    aw_wait = 0;

    // Reset while AW is pending.
    aw_wait = 5; w_wait = 5;
    start_cmd(1'b1, 32'h00, 32'h0000FFFF, 4'hF);
    @(posedge clk); #1;
    check("rstmid_awvalid_before", 32'(m_axi_awvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_axi_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                m_axi_bready, m_axi_rready}, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_err_count", 32'(err_count), 32'd0);
    aw_wait = 0; w_wait = 0;
    @(posedge clk); #1;
    check("rstmid_idle_after", {30'd0, rsp_valid, cmd_ready}, 32'b01);

    // Error counting and saturation.
    rd_err = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      start_cmd(1'b0, 32'h00, 32'h0, 4'h0);
      wait_rsp(extra);
      check("err_rsp_resp", 32'(rsp_resp), 32'h2);
      check("err_count_inc", 32'(err_count), 32'(i));
      complete();
    end
    force dut.r_err_count = 16'hFFFF;
    #2 release dut.r_err_count;
    @(posedge clk); #1;
    check("err_preload", 32'(err_count), 32'h0000FFFF);
    start_cmd(1'b0, 32'h04, 32'h0, 4'h0);
    wait_rsp(extra);
    check("err_sat_resp", 32'(rsp_resp), 32'h2);
    check("err_saturated", 32'(err_count), 32'h0000FFFF);
    complete();
    rd_err = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
